// File: rtl/lianliankan_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the pushbutton front end: channel FSM states,
// direction indices and default timing constants at 100 MHz.
package lianliankan_pkg;

  typedef enum logic [2:0] {
    ST_RELEASED,
    ST_PRESS_DB,
    ST_HELD_DELAY,
    ST_HELD_REPEAT,
    ST_HELD_IDLE,
    ST_RELEASE_DB
  } btn_state_t;

  localparam int UP       = 0;
  localparam int DOWN     = 1;
  localparam int LEFT     = 2;
  localparam int RIGHT    = 3;
  localparam int NUM_DIRS = 4;

  // 5 ms debounce, 250 ms first repeat, 100 ms repeat period
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_REPEAT_DELAY    = 25000000;
  localparam int DEFAULT_REPEAT_PERIOD   = 10000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
`timescale 1ns/1ps
// One button channel: 2-flop synchronizer, debounce FSM and optional
// auto-repeat. The pulse output is combinational; the top registers it.
module debounce_channel
  import lianliankan_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD);

  logic             sync_q1;
  logic             sync;
  btn_state_t       state;
  btn_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync    <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A low level always wins over a compare hit, so a release never
  // coincides with a pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse     = 1'b0;
    case (state)
      ST_RELEASED: begin
        if (sync) begin
          state_nxt = ST_PRESS_DB;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_PRESS_DB: begin
        if (!sync) begin
          state_nxt = ST_RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = REPEAT_EN ? ST_HELD_DELAY : ST_HELD_IDLE;
          cnt_nxt   = CNT_ONE;
          pulse     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HELD_DELAY: begin
        if (!sync) begin
          state_nxt = ST_RELEASE_DB;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == DELAY_LAST) begin
          state_nxt = ST_HELD_REPEAT;
          cnt_nxt   = CNT_ONE;
          pulse     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HELD_REPEAT: begin
        if (!sync) begin
          state_nxt = ST_RELEASE_DB;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == PERIOD_LAST) begin
          cnt_nxt = CNT_ONE;
          pulse   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HELD_IDLE: begin
        if (!sync) begin
          state_nxt = ST_RELEASE_DB;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_RELEASE_DB: begin
        // A bounce back high resumes the hold silently
        if (sync) begin
          state_nxt = REPEAT_EN ? ST_HELD_REPEAT : ST_HELD_IDLE;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_pulser.sv
`timescale 1ns/1ps
// Five-button input conditioner: four auto-repeating direction channels
// behind a fixed-priority arbiter plus a single-shot select channel.
module button_pulser
  import lianliankan_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_s,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic s
);

  logic [NUM_DIRS-1:0] dir_raw;
  logic [NUM_DIRS-1:0] dir_req;
  logic [NUM_DIRS-1:0] dir_grant;
  logic                s_req;

  assign dir_raw[UP]    = btn_up;
  assign dir_raw[DOWN]  = btn_down;
  assign dir_raw[LEFT]  = btn_left;
  assign dir_raw[RIGHT] = btn_right;

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_dir
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (1'b1)
    ) u_dir (
      .clk   (clk),
      .rst   (rst),
      .raw   (dir_raw[i]),
      .pulse (dir_req[i])
    );
  end

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_EN       (1'b0)
  ) u_sel (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_s),
    .pulse (s_req)
  );

  // Losing requests are dropped, never queued
  always_comb begin
    dir_grant = '0;
    if (dir_req[UP])         dir_grant[UP]    = 1'b1;
    else if (dir_req[DOWN])  dir_grant[DOWN]  = 1'b1;
    else if (dir_req[LEFT])  dir_grant[LEFT]  = 1'b1;
    else if (dir_req[RIGHT]) dir_grant[RIGHT] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up    <= 1'b0;
      down  <= 1'b0;
      left  <= 1'b0;
      right <= 1'b0;
      s     <= 1'b0;
    end else begin
      up    <= dir_grant[UP];
      down  <= dir_grant[DOWN];
      left  <= dir_grant[LEFT];
      right <= dir_grant[RIGHT];
      s     <= s_req;
    end
  end

endmodule

// File: tb/tb_button_pulser.sv
`timescale 1ns/1ps
// Directed bench for button_pulser with DEBOUNCE=4, DELAY=20, PERIOD=8.
// A press driven just after edge c0 shows its pulse at edge c0+7.
module tb_button_pulser;

  logic clk;
  logic rst;
  logic btn_up, btn_down, btn_left, btn_right, btn_s;
  logic up, down, left, right, s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dir_multi = 0;
  int c0;
  int up_t[$], down_t[$], left_t[$], right_t[$], s_t[$];
  int sweep_seq[10] = '{1, 1, 4, 1, 4, 3, 0, 4, 2, 1};
  logic [4:0] press_vec;

  button_pulser #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_s     (btn_s),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .s         (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order {s, right, left, down, up}
  task automatic applyStimulus(input logic [4:0] btns);
    {btn_s, btn_right, btn_left, btn_down, btn_up} = btns;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clearLogs();
    up_t.delete(); down_t.delete(); left_t.delete(); right_t.delete(); s_t.delete();
  endtask

  // Advance n edges, logging the edge number of every output pulse
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (up)    up_t.push_back(cyc);
      if (down)  down_t.push_back(cyc);
      if (left)  left_t.push_back(cyc);
      if (right) right_t.push_back(cyc);
      if (s)     s_t.push_back(cyc);
      if ($countones({up, down, left, right}) > 1) dir_multi++;
    end
  endtask

  function automatic int nth(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  function automatic int countFor(input int idx);
    case (idx)
      0: return up_t.size();
      1: return down_t.size();
      2: return left_t.size();
      3: return right_t.size();
      default: return s_t.size();
    endcase
  endfunction

  function automatic int firstFor(input int idx);
    case (idx)
      0: return nth(up_t, 0);
      1: return nth(down_t, 0);
      2: return nth(left_t, 0);
      3: return nth(right_t, 0);
      default: return nth(s_t, 0);
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    applyStimulus(5'b00000);
    tick(3);
    checkOutput("reset_outputs", int'({up, down, left, right, s}), 0);
    rst = 1'b1;

    // Clean press on down: pulses at +7, +27, +35 ... +99, then silence
    clearLogs();
    c0 = cyc;
    applyStimulus(5'b00010);
    tick(100);
    checkOutput("press_first",   nth(down_t, 0),  c0 + 7);
    checkOutput("press_rep1",    nth(down_t, 1),  c0 + 27);
    checkOutput("press_rep2",    nth(down_t, 2),  c0 + 35);
    checkOutput("press_rep_last", nth(down_t, 10), c0 + 99);
    applyStimulus(5'b00000);
    tick(30);
    checkOutput("press_count", down_t.size(), 11);
    checkOutput("press_others", up_t.size() + left_t.size() + right_t.size() + s_t.size(), 0);

    // Bouncing select, then a steady hold
    clearLogs();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'b10000);
      tick(2);
      applyStimulus(5'b00000);
      tick(2);
    end
    checkOutput("bounce_quiet", s_t.size(), 0);
    c0 = cyc;
    applyStimulus(5'b10000);
    tick(200);
    checkOutput("bounce_time",   nth(s_t, 0), c0 + 7);
    checkOutput("bounce_single", s_t.size(), 1);
    applyStimulus(5'b00000);
    tick(20);

    // Up, left and select together: up wins, select unaffected
    clearLogs();
    c0 = cyc;
    applyStimulus(5'b10101);
    tick(40);
    checkOutput("simul_up_time", nth(up_t, 0), c0 + 7);
    checkOutput("simul_s_time",  nth(s_t, 0),  c0 + 7);
    checkOutput("simul_left",    left_t.size(), 0);
    checkOutput("simul_up_count", up_t.size(), 3);
    applyStimulus(5'b00000);
    tick(20);

    // Right held: a 3-cycle dip only restarts the period, a 10-cycle gap re-presses
    clearLogs();
    c0 = cyc;
    applyStimulus(5'b01000);
    tick(44);
    checkOutput("glitch_pre_count", right_t.size(), 4);
    checkOutput("glitch_pre_last",  nth(right_t, 3), c0 + 43);
    applyStimulus(5'b00000);
    tick(3);
    applyStimulus(5'b01000);
    tick(23);
    checkOutput("glitch_resume1", nth(right_t, 4), c0 + 58);
    checkOutput("glitch_resume2", nth(right_t, 5), c0 + 66);
    applyStimulus(5'b00000);
    tick(10);
    checkOutput("glitch_gap_quiet", right_t.size(), 6);
    applyStimulus(5'b01000);
    tick(10);
    checkOutput("glitch_repress", nth(right_t, 6), c0 + 87);
    checkOutput("glitch_count",   right_t.size(), 7);
    applyStimulus(5'b00000);
    tick(20);

    // Reset asserted while up is pulsing during repeat
    clearLogs();
    c0 = cyc;
    applyStimulus(5'b00001);
    tick(27);
    checkOutput("rst_pre_rep",  nth(up_t, 1), c0 + 27);
    checkOutput("rst_pre_high", int'(up), 1);
    rst = 1'b0;
    #1;
    checkOutput("rst_async_clear", int'({up, down, left, right, s}), 0);
    tick(3);
    checkOutput("rst_hold_quiet", up_t.size(), 2);
    rst = 1'b1;
    clearLogs();
    tick(10);
    checkOutput("rst_repress_time",  nth(up_t, 0), c0 + 37);
    checkOutput("rst_repress_count", up_t.size(), 1);
    applyStimulus(5'b00000);
    tick(20);

    // Game-like sequence of 50-cycle presses; a direction repeats at +7,27,35,43,51
    for (int k = 0; k < 10; k++) begin
      clearLogs();
      c0 = cyc;
      press_vec = 5'b00001 << sweep_seq[k];
      applyStimulus(press_vec);
      tick(50);
      applyStimulus(5'b00000);
      tick(20);
      checkOutput($sformatf("sweep%0d_first", k), firstFor(sweep_seq[k]), c0 + 7);
      checkOutput($sformatf("sweep%0d_count", k), countFor(sweep_seq[k]),
                  (sweep_seq[k] == 4) ? 1 : 5);
      checkOutput($sformatf("sweep%0d_others", k),
                  up_t.size() + down_t.size() + left_t.size() + right_t.size() + s_t.size()
                  - countFor(sweep_seq[k]), 0);
    end

    checkOutput("dir_onehot", dir_multi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_pulser.md
# button_pulser

Front-end input conditioner for the five pushbuttons: up, down, left, right and select. It is the producing end of the single-cycle pulse interface that `cursor` (up/down/left/right) and `card_array` (`s`) consume. It synchronizes, debounces, edge-detects and auto-repeats raw board buttons. Every output is a clean pulse exactly one `clk` cycle wide, the same shape the game logic is driven with in simulation.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronized cycles required to accept a level change. Must be ≥ 1.
- `REPEAT_DELAY`, 25000000: cycles from the accepted press pulse to the first auto-repeat pulse on direction keys. Must be ≥ 1.
- `REPEAT_PERIOD`, 10000000: cycles between subsequent auto-repeat pulses. Must be ≥ 1.
- `clk` in 1: system clock. This is the only clock.
- `rst` in 1: reset. Asynchronous, active-low (0 = reset).
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_s` in 1 each: raw, asynchronous, active-high buttons.
- `up`, `down`, `left`, `right` out 1 each: one-cycle direction pulses to `cursor`.
- `s` out 1: one-cycle select pulse to `card_array`.

## Operation
- Per button: a 2-flop synchronizer feeds a per-channel FSM with a shared-width counter `cnt`. Counter width is `$clog2` of the largest parameter, +1.
- FSM states and transitions:
  - RELEASED: stable level 0.
    - sync=1 → PRESS_DB, `cnt`=1.
  - PRESS_DB:
    - sync=0 → RELEASED.
    - `cnt`==DEBOUNCE_CYCLES → HELD_DELAY, press pulse fires, `cnt`=1.
    - Otherwise `cnt`++.
  - HELD_DELAY, direction channels only (select goes to HELD_IDLE instead):
    - sync=0 → RELEASE_DB.
    - `cnt`==REPEAT_DELAY → HELD_REPEAT, repeat pulse fires, `cnt`=1.
  - HELD_REPEAT:
    - sync=0 → RELEASE_DB.
    - `cnt`==REPEAT_PERIOD → repeat pulse fires, `cnt`=1.
  - HELD_IDLE, select only: no pulses.
    - sync=0 → RELEASE_DB.
  - RELEASE_DB:
    - sync=1 → back to the held state it came from, with no pulse. Select returns to HELD_IDLE; a direction key returns to HELD_REPEAT with `cnt`=1.
    - `cnt`==DEBOUNCE_CYCLES → RELEASED.
- Select never auto-repeats. Exactly one `s` pulse per accepted press.
- Direction arbitration, with fixed priority up > down > left > right:
  - If two or more direction channels request a pulse in the same cycle, only the highest-priority one is output.
  - The others are dropped, not queued.
  - At most one of `up`/`down`/`left`/`right` is high in any cycle.
  - `s` is independent and may coincide with a direction pulse.
- Outputs are registered. Pulse width is exactly 1 cycle. There are no back-to-back pulses on one output unless REPEAT_PERIOD==1.

## Timing
- Reset (`rst`=0, asynchronous):
  - All outputs 0, all FSMs RELEASED, synchronizers 0, counters 0.
  - Takes effect immediately, mid-debounce or mid-repeat.
  - A button still held when `rst` deasserts is seen as a fresh press and produces one pulse after the normal latency.
- Press latency: raw rises before clock edge E0 and stays high. Sync is high after E1, PRESS_DB entered at E2, and the output pulse is high in the cycle after edge E(2+DEBOUNCE_CYCLES).
- First repeat: REPEAT_DELAY cycles after the press pulse. Subsequent repeats every REPEAT_PERIOD cycles.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no pulse and no state change.
- Release latency: DEBOUNCE_CYCLES+2 cycles. The next press is accepted only after that.
- Counters saturate by construction, since they are reset on every compare hit. There is no wrap-around.

## Structure
- Shared package `lianliankan_pkg`:
  - Channel FSM state enum.
  - Direction index constants UP=0, DOWN=1, LEFT=2, RIGHT=3.
  - Default debounce and repeat constants at 100 MHz.
- Sub-module `debounce_channel`:
  - Parameters: `DEBOUNCE_CYCLES`, `REPEAT_DELAY`, `REPEAT_PERIOD`, `REPEAT_EN`.
  - Ports: `clk`, `rst`, `raw`, `pulse`.
  - Instantiated five times, with `REPEAT_EN`=0 for select.
- Top level contains only the instances, the priority arbiter and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, with a 10 ns clock.
- Clean press: `btn_down` held 100 cycles → one `down` pulse 6 cycles after the rise, then repeats at +20, +28, +36 and so on. No pulse after release.
- Bounce: `btn_s` toggled 1/0 every 2 cycles for 20 cycles, then held high → exactly one `s` pulse, 6 cycles after the final rise. Holding `btn_s` for 200 cycles gives no further pulses.
- Simultaneous: `btn_left` and `btn_up` rise in the same cycle → only `up` pulses. `left` stays 0 for that event. `btn_s` rising at the same time still pulses `s` in the same cycle.
- Release glitch: while `btn_right` is held in repeat, a 3-cycle low dip gives no new press pulse and repeats continue. A 10-cycle low followed by a press gives a fresh pulse after 6 cycles.
- Reset mid-operation: `rst` low for 3 cycles during the `btn_up` repeat phase → outputs 0 immediately. With `btn_up` still held, one `up` pulse occurs 6 cycles after `rst` rises.
- Sweep: replay the game-driving sequence (down, down, s, down, s, …) as 50-cycle raw presses → the output pulse sequence matches the press sequence one-to-one.
